rv32i_mem_arbiter: RTL and testbench
====================================

// Module: rv32i_mem_arbiter
// PURPOSE
// - Shares one single-port memory between the RV32I instruction-fetch port (IF) and load/store data port (D).
// - Sits between the core and unified memory; top-level RV32I instantiates it.
// - Grants one requester at a time, holds the memory transaction until mem_ready, returns response to the owner.
// - Aborts a stalled transaction after a bounded timeout.
// PARAMETERS
// - ADDR_W   32   address width, both ports and memory
// - DATA_W   32   data width; byte-enable width is DATA_W/8
// - TIMEOUT  255  max cycles waiting for mem_ready before abort; 0 = no timeout
// PORTS
// - clk        in   1         system clock, all logic on rising edge
// - rst        in   1         synchronous, active-high reset
// - if_req     in   1         fetch request; held with if_addr until if_gnt
// - if_addr    in   ADDR_W    fetch address
// - if_gnt     out  1         1-cycle pulse: fetch request accepted
// - if_rvalid  out  1         1-cycle pulse: fetch response valid
// - if_rdata   out  DATA_W    fetched word, valid with if_rvalid
// - if_err     out  1         with if_rvalid: transaction timed out
// - d_req      in   1         data request; held with d_* until d_gnt
// - d_we       in   1         1 = store, 0 = load
// - d_be       in   DATA_W/8  byte enables (store only)
// - d_addr     in   ADDR_W    data address
// - d_wdata    in   DATA_W    store data
// - d_gnt      out  1         1-cycle pulse: data request accepted
// - d_rvalid   out  1         1-cycle pulse: load data / store ack
// - d_rdata    out  DATA_W    load data; 0 for store acks
// - d_err      out  1         with d_rvalid: transaction timed out
// - mem_req    out  1         memory request; held until mem_ready sampled high
// - mem_we     out  1         memory write enable
// - mem_be     out  DATA_W/8  memory byte enables (all ones for fetch)
// - mem_addr   out  ADDR_W    memory address
// - mem_wdata  out  DATA_W    memory write data
// - mem_ready  in   1         memory completes transaction this cycle
// - mem_rdata  in   DATA_W    read data, valid when mem_ready=1 and mem_we=0
// - busy       out  1         1 whenever state != IDLE
// BEHAVIOUR
// - All outputs registered. Reset: state=IDLE, all pulses/mem_req/busy=0, data/addr outputs=0, timeout counter=0.
// - FSM: IDLE -> IF_BUSY | D_BUSY -> IDLE. No request is accepted while BUSY.
// - IDLE, cycle N, a request present: select owner; at N+1 pulse owner's gnt, drive mem_* from latched request, mem_req=1, busy=1.
// - Fetch: mem_we=0, mem_be=all ones, mem_wdata=0.
// - BUSY: mem_* stable; counter increments each cycle mem_ready=0.
// - mem_ready=1 in cycle M: next cycle pulse owner rvalid, rdata=mem_rdata (0 if store), err=0; mem_req=0; return to IDLE.
// - Minimum latency req->rvalid: 2 cycles. Back-to-back service: next gnt one cycle after rvalid.
// - Timeout: counter reaches TIMEOUT with mem_ready=0 -> drop mem_req, pulse owner rvalid with err=1, rdata=0, return to IDLE.
// - mem_ready while IDLE: ignored.
// - Requester dropping req before gnt: legal; request forgotten, no gnt issued.
// - rst asserted mid-transaction: immediate return to IDLE next edge; no rvalid for aborted transaction; memory tolerates withdrawn mem_req.
// - Never both gnt at once; never both rvalid at once.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined: 1-bit last-owner flag (reset to IF).
//   On simultaneous requests, grant the port that was NOT last owner; flag updates on each gnt.
// - Not defined: fixed priority, D always wins simultaneous requests (IF may starve under continuous D traffic).
// - Single requests behave identically in both builds.
// TESTING
// - Single fetch: if_req=1, addr=0x100, mem_ready after 1 cycle, rdata=0x00500093 -> if_gnt @+1, if_rvalid @+2, if_rdata=0x00500093.
// - Store: d_we=1, be=4'b0011, addr=0x2004, wdata=0xA5A5 -> mem_we=1, mem_be=0011, mem_wdata=0xA5A5; d_rvalid with d_rdata=0.
// - Simultaneous IF+D held 3 transactions: no macro -> D,D,D; with ARB_ROUND_ROBIN_EN -> D,IF,D.
// - Timeout: TIMEOUT=4, mem_ready tied 0 -> mem_req drops, d_rvalid=1 with d_err=1 exactly 4 busy cycles after gnt.
// - Reset mid-load: rst=1 while D_BUSY -> next cycle busy=0, mem_req=0, no d_rvalid; fresh if_req served normally afterwards.
// - Wait states: mem_ready delayed 3 cycles -> mem_addr/mem_we stable throughout, single rvalid pulse, err=0.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between RV32I instruction fetch (IF) and load/store (D) ports.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed D priority.
module rv32i_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    // state   | meaning
    // IDLE    | no transaction, arbitrating incoming requests
    // IF_BUSY | fetch owns memory, waiting for mem_ready or timeout
    // D_BUSY  | data port owns memory, waiting for mem_ready or timeout

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_TC = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic              pick_d;

    logic              if_gnt_nxt, if_rvalid_nxt, if_err_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic              d_gnt_nxt, d_rvalid_nxt, d_err_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [BE_W-1:0]   mem_be_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d, last_d_nxt;

    // On a tie, the port that did not win last time gets the grant.
    assign pick_d = d_req && (!if_req || !last_d);
`else
    assign pick_d = d_req;
`endif

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        if_gnt_nxt    = 1'b0;
        if_rvalid_nxt = 1'b0;
        if_rdata_nxt  = '0;
        if_err_nxt    = 1'b0;
        d_gnt_nxt     = 1'b0;
        d_rvalid_nxt  = 1'b0;
        d_rdata_nxt   = '0;
        d_err_nxt     = 1'b0;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_be_nxt    = mem_be;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_nxt    = last_d;
`endif

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pick_d) begin
                    state_nxt     = D_BUSY;
                    d_gnt_nxt     = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_be_nxt    = d_be;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_nxt    = 1'b1;
`endif
                end else if (if_req) begin
                    state_nxt     = IF_BUSY;
                    if_gnt_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_be_nxt    = '1;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_nxt    = 1'b0;
`endif
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ready) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    cnt_nxt     = '0;
                    if (state == IF_BUSY) begin
                        if_rvalid_nxt = 1'b1;
                        if_rdata_nxt  = mem_rdata;
                    end else begin
                        d_rvalid_nxt = 1'b1;
                        d_rdata_nxt  = mem_we ? '0 : mem_rdata;
                    end
                end else if (TO_EN && (cnt_inc == TO_TC)) begin
                    // Stalled memory: release the bus and report an error to the owner.
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    cnt_nxt     = '0;
                    if (state == IF_BUSY) begin
                        if_rvalid_nxt = 1'b1;
                        if_err_nxt    = 1'b1;
                    end else begin
                        d_rvalid_nxt = 1'b1;
                        d_err_nxt    = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
                cnt_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if_gnt    <= if_gnt_nxt;
            if_rvalid <= if_rvalid_nxt;
            if_rdata  <= if_rdata_nxt;
            if_err    <= if_err_nxt;
            d_gnt     <= d_gnt_nxt;
            d_rvalid  <= d_rvalid_nxt;
            d_rdata   <= d_rdata_nxt;
            d_err     <= d_err_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_be    <= mem_be_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= (state_nxt != IDLE);
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= last_d_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed self-checking bench for rv32i_mem_arbiter (built with TIMEOUT=4).
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000000",
                     {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy});
        end
        checks++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata, mem_be} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h %h expected all zero",
                     if_rdata, d_rdata, mem_addr, mem_wdata, mem_be);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        checks++;
        if ({if_gnt, d_gnt, mem_req, mem_we, busy} !== 5'b10101 || mem_addr !== 32'h100 ||
            mem_be !== 4'hf || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_gnt: got gnt=%b dgnt=%b req=%b we=%b busy=%b addr=%h be=%h wd=%h expected 1 0 1 0 1 100 f 0",
                     if_gnt, d_gnt, mem_req, mem_we, busy, mem_addr, mem_be, mem_wdata);
        end
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h00500093;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({if_rvalid, if_err, d_rvalid, mem_req, busy} !== 5'b10000 || if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_rvalid: got rv=%b err=%b drv=%b req=%b busy=%b rdata=%h expected 1 0 0 0 0 00500093",
                     if_rvalid, if_err, d_rvalid, mem_req, busy, if_rdata);
        end
        tick();
        checks++;
        if ({if_rvalid, if_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_pulse: got rv=%b gnt=%b expected 0 0", if_rvalid, if_gnt);
        end
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h2004;
        d_wdata = 32'hA5A5;
        tick();
        checks++;
        if ({d_gnt, if_gnt, mem_req, mem_we} !== 4'b1011 || mem_be !== 4'b0011 ||
            mem_addr !== 32'h2004 || mem_wdata !== 32'hA5A5) begin
            errors++;
            $display("FAIL store_gnt: got gnt=%b igt=%b req=%b we=%b be=%b addr=%h wd=%h expected 1 0 1 1 0011 2004 a5a5",
                     d_gnt, if_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        d_req     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({d_rvalid, d_err, if_rvalid, mem_req} !== 4'b1000 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL store_ack: got rv=%b err=%b irv=%b req=%b rdata=%h expected 1 0 0 0 0",
                     d_rvalid, d_err, if_rvalid, mem_req, d_rdata);
        end
        tick();
    endtask

    task automatic test_wait_states();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'hf;
        d_addr = 32'h3000;
        tick();
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wait_gnt: got %b expected 1", d_gnt);
        end
        d_req  = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h500;
        for (int i = 0; i < 3; i++) begin
            tick();
            if_req = 1'b0;
            checks++;
            if ({mem_req, mem_we, d_rvalid, busy} !== 4'b1001 || mem_addr !== 32'h3000) begin
                errors++;
                $display("FAIL wait_stable%0d: got req=%b we=%b rv=%b busy=%b addr=%h expected 1 0 0 1 3000",
                         i, mem_req, mem_we, d_rvalid, busy, mem_addr);
            end
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({d_rvalid, d_err, if_gnt} !== 3'b100 || d_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL wait_rvalid: got rv=%b err=%b igt=%b rdata=%h expected 1 0 0 12345678",
                     d_rvalid, d_err, if_gnt, d_rdata);
        end
        tick();
        checks++;
        if ({d_rvalid, if_gnt, busy} !== 3'b000) begin
            errors++;
            $display("FAIL wait_single: got rv=%b igt=%b busy=%b expected 0 0 0", d_rvalid, if_gnt, busy);
        end
    endtask

    task automatic test_timeout();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h4000;
        mem_rdata = 32'hCAFEF00D;
        tick();
        d_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({mem_req, d_rvalid, busy} !== 3'b101) begin
                errors++;
                $display("FAIL timeout_wait%0d: got req=%b rv=%b busy=%b expected 1 0 1",
                         i, mem_req, d_rvalid, busy);
            end
        end
        tick();
        checks++;
        if ({d_rvalid, d_err, mem_req, busy} !== 4'b1100 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort: got rv=%b err=%b req=%b busy=%b rdata=%h expected 1 1 0 0 0",
                     d_rvalid, d_err, mem_req, busy, d_rdata);
        end
        tick();
        checks++;
        if ({d_rvalid, d_err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got rv=%b err=%b expected 0 0", d_rvalid, d_err);
        end
    endtask

    task automatic test_reset_mid();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h6000;
        tick();
        d_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, mem_req, d_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_abort: got busy=%b req=%b rv=%b expected 0 0 0", busy, mem_req, d_rvalid);
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if ({d_rvalid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_norv: got rv=%b busy=%b expected 0 0", d_rvalid, busy);
        end
        mem_ready = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h200;
        tick();
        checks++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL rstmid_gnt: got gnt=%b addr=%h expected 1 200", if_gnt, mem_addr);
        end
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h11;
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({if_rvalid, if_err} !== 2'b10 || if_rdata !== 32'h11) begin
            errors++;
            $display("FAIL rstmid_rv: got rv=%b err=%b rdata=%h expected 1 0 11", if_rvalid, if_err, if_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_d [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        if_req    = 1'b1;
        if_addr   = 32'h800;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h9000;
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if ({d_gnt, if_gnt} !== {exp_d[t], ~exp_d[t]} ||
                mem_addr !== (exp_d[t] ? 32'h9000 : 32'h800)) begin
                errors++;
                $display("FAIL arb_gnt%0d: got dgnt=%b igt=%b addr=%h expected %b %b %h",
                         t, d_gnt, if_gnt, mem_addr, exp_d[t], ~exp_d[t],
                         exp_d[t] ? 32'h9000 : 32'h800);
            end
            if (t == 2) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();
            checks++;
            if ({d_rvalid, if_rvalid, d_gnt, if_gnt} !== {exp_d[t], ~exp_d[t], 2'b00}) begin
                errors++;
                $display("FAIL arb_rv%0d: got drv=%b irv=%b dgnt=%b igt=%b expected %b %b 0 0",
                         t, d_rvalid, if_rvalid, d_gnt, if_gnt, exp_d[t], ~exp_d[t]);
            end
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({mem_req, busy, d_gnt, if_gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL arb_idle: got req=%b busy=%b dgnt=%b igt=%b expected 0 0 0 0",
                     mem_req, busy, d_gnt, if_gnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_be      = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        test_reset();
        test_single_fetch();
        test_store();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
